// File: rtl/fp_operand_unpack_stage.sv
// Operand-preparation stage ahead of the dual-path adder: unpacks two IEEE-754
// singles into flags/exponent/significand and normalises subnormals over several cycles.
module fp_operand_unpack_stage #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_add,
  input  logic [2:0]  in_rounding_mode,
  input  logic [31:0] in_f,
  input  logic [31:0] in_g,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_add,
  output logic [2:0]  out_rounding_mode,
  output logic        uf_nan,
  output logic        uf_inf,
  output logic        uf_zero,
  output logic        uf_subnormal,
  output logic        uf_sign,
  output logic [9:0]  uf_exponent,
  output logic [23:0] uf_significand,
  output logic        ug_nan,
  output logic        ug_inf,
  output logic        ug_zero,
  output logic        ug_subnormal,
  output logic        ug_sign,
  output logic [9:0]  ug_exponent,
  output logic [23:0] ug_significand
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        zero;
    logic        sub;
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
  } unp_t;

  function automatic unp_t unpack(input logic [31:0] x);
    unp_t       u;
    logic [7:0] e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    u = '0;
    u.sign = x[31];
    if (e == 8'h00) begin
      if (m == '0) begin
        u.zero = 1'b1;
      end else begin
        u.sub = 1'b1;
        u.exp = 10'h382;
        u.sig = {1'b0, m};
      end
    end else if (e == 8'hFF) begin
      u.exp = 10'h0FF;
      if (m == '0) u.inf = 1'b1;
      else         u.nan = 1'b1;
    end else begin
      u.exp = {2'b00, e} - 10'd127;
      u.sig = {1'b1, m};
    end
    return u;
  endfunction

  // A wide step is only taken when it cannot push the leading one past bit 23.
  function automatic unp_t norm_step(input unp_t u);
    unp_t r;
    r = u;
    if (u.sub && !u.sig[23]) begin
      if (u.sig[23 -: SHIFT_STEP] == '0) begin
        r.sig = u.sig << SHIFT_STEP;
        r.exp = u.exp - 10'(SHIFT_STEP);
      end else begin
        r.sig = u.sig << 1;
        r.exp = u.exp - 10'd1;
      end
    end
    return r;
  endfunction

  state_t r_state, w_next;
  unp_t   r_f, r_g;
  logic   r_is_add;
  logic [2:0] r_rm;
  logic   r_live;

  unp_t   w_uf, w_ug, w_nf, w_ng;
  logic   w_in_ready, w_accept, w_any_sub, w_norm_done;

  assign w_uf        = unpack(in_f);
  assign w_ug        = unpack(in_g);
  assign w_nf        = norm_step(r_f);
  assign w_ng        = norm_step(r_g);
  assign w_any_sub   = w_uf.sub | w_ug.sub;
  assign w_norm_done = (!w_nf.sub | w_nf.sig[23]) & (!w_ng.sub | w_ng.sig[23]);

  // r_live keeps in_ready low while reset is asserted even though the FSM sits in IDLE.
  assign w_in_ready = r_live & ((r_state == S_IDLE) | ((r_state == S_VALID) & out_ready));
  assign w_accept   = in_valid & w_in_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_any_sub ? S_NORM : S_VALID;
      end
      S_NORM: begin
        if (w_norm_done) w_next = S_VALID;
      end
      S_VALID: begin
        if (out_ready) begin
          if (w_accept) w_next = w_any_sub ? S_NORM : S_VALID;
          else          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_f      <= '0;
      r_g      <= '0;
      r_is_add <= 1'b0;
      r_rm     <= '0;
      r_live   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_f      <= w_uf;
        r_g      <= w_ug;
        r_is_add <= in_is_add;
        r_rm     <= in_rounding_mode;
      end else if (r_state == S_NORM) begin
        r_f <= w_nf;
        r_g <= w_ng;
      end
    end
  end

  assign in_ready          = w_in_ready;
  assign out_valid         = (r_state == S_VALID);
  assign out_is_add        = r_is_add;
  assign out_rounding_mode = r_rm;

  assign uf_nan         = r_f.nan;
  assign uf_inf         = r_f.inf;
  assign uf_zero        = r_f.zero;
  assign uf_subnormal   = r_f.sub;
  assign uf_sign        = r_f.sign;
  assign uf_exponent    = r_f.exp;
  assign uf_significand = r_f.sig;

  assign ug_nan         = r_g.nan;
  assign ug_inf         = r_g.inf;
  assign ug_zero        = r_g.zero;
  assign ug_subnormal   = r_g.sub;
  assign ug_sign        = r_g.sign;
  assign ug_exponent    = r_g.exp;
  assign ug_significand = r_g.sig;

endmodule

// File: doc/fp_operand_unpack_stage.md
Name: fp_operand_unpack_stage

Overview:
- Registered, handshaked operand-preparation stage that sits directly upstream of the dual-path adder core.
- Accepts a packed IEEE-754 single-precision add/sub request and splits both operands into unpacked fields: nan/inf/zero/subnormal/sign flags, 10-bit two's-complement unbiased exponent, and 24-bit significand with explicit leading bit.
- Normalises subnormal operands with a multi-cycle shift FSM, so the adder core only ever sees significands with bit 23 set.
- Holds the result under back-pressure until the consumer takes it.

Parameters:
- SHIFT_STEP, 1, max left-shift per NORM cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  request present
- in_ready  output  1  stage can accept this cycle
- in_is_add  input  1  1 = add, 0 = subtract
- in_rounding_mode  input  3  RNE=0, RNA=1, RTP=2, RTN=3, RTZ=4; passed through unchanged
- in_f  input  32  packed operand f
- in_g  input  32  packed operand g
- out_valid  output  1  unpacked pair available
- out_ready  input  1  consumer accepts
- out_is_add  output  1  registered copy of in_is_add
- out_rounding_mode  output  3  registered copy of in_rounding_mode
- uf_nan, uf_inf, uf_zero, uf_subnormal, uf_sign  output  1 each  operand f flags
- uf_exponent  output  10  operand f unbiased exponent, two's complement
- uf_significand  output  24  operand f significand
- ug_nan, ug_inf, ug_zero, ug_subnormal, ug_sign  output  1 each  operand g flags
- ug_exponent  output  10  operand g unbiased exponent, two's complement
- ug_significand  output  24  operand g significand

Behaviour:
- Reset: while rst_n=0, FSM is in IDLE and every output register is 0, so out_valid=0, all flags, exponents and significands are 0, and in_ready=0. in_ready goes to 1 in the first cycle after release.
- Unpack rules, applied per operand at capture time (e = bits 30:23, m = bits 22:0, sign = bit 31):
  - e=0, m=0: zero=1; exponent 0; significand 0.
  - e=0, m≠0: subnormal=1; exponent -126 (0x382); significand {1'b0, m}.
  - e=0xFF, m=0: inf=1; exponent 0x0FF; significand 0.
  - e=0xFF, m≠0: nan=1; exponent 0x0FF; significand 0.
  - Otherwise: exponent e-127, sign-extended to 10 bits; significand {1'b1, m}.
  - Exactly one of nan/inf/zero/subnormal is set, or none for normal operands.
- FSM states: IDLE, NORM, VALID.
- in_ready = (state==IDLE) | (state==VALID & out_ready). in_ready is 0 in NORM.
- Accept (in_valid & in_ready at an edge): capture the unpacked fields.
  - If neither operand is subnormal, go to VALID; out_valid=1 the cycle after acceptance (latency 1).
  - Otherwise go to NORM.
- NORM, each cycle, for each subnormal operand whose significand bit 23 = 0:
  - If the top SHIFT_STEP bits are all 0, shift left SHIFT_STEP and subtract SHIFT_STEP from the exponent.
  - Otherwise shift left 1 and subtract 1.
  - When both significands have bit 23 = 1 after the update, go to VALID.
  - The subnormal flag stays 1. Normal or special operands are untouched.
  - With SHIFT_STEP=1, the NORM cycle count is max(lz_f, lz_g), where lz is the number of shifts needed to set bit 23 (1..23). out_valid asserts that many edges after acceptance.
- VALID: outputs are stable while out_valid=1 & out_ready=0.
  - out_ready=1 without a new accept: go to IDLE, out_valid=0 next cycle.
  - out_ready=1 with a new accept in the same cycle: capture the new request and go to VALID or NORM as above. This gives throughput of 1 per cycle for non-subnormal traffic.
- Exponent arithmetic is 10-bit two's complement. The minimum reachable value is -149 (0x36B), so there is no wrap.
- Asynchronous reset mid-NORM or mid-VALID drops the transaction; no partial output is ever presented.
- in_valid inputs are ignored when in_ready=0; there is no internal queue beyond the single output register.

Test Plan:
- f=0x3F800000, g=0x40000000, add, out_ready=1 → out_valid 1 cycle after accept; uf_exponent=0x000, ug_exponent=0x001, both significands 0x800000, all flags 0.
- f=0x00000001, g=0x3F800000 → 23 NORM cycles with in_ready=0; then uf_subnormal=1, uf_exponent=0x36B, uf_significand=0x800000; g unchanged.
- f=0x7FC00000, g=0xFF800000 → latency 1; uf_nan=1, uf_exponent=0x0FF, uf_significand=0; ug_inf=1, ug_sign=1.
- Three normal requests on consecutive cycles with out_ready=1 → in_ready stays 1; out_valid high 3 consecutive cycles carrying each pair in order.
- Accept a request, then hold out_ready=0 for 5 cycles → outputs unchanged, in_ready=0; raise out_ready → handshake completes and in_ready=1 that cycle.
- f=0x00000001 accepted, rst_n pulsed low after 5 NORM cycles → all outputs 0 immediately; after release, in_ready=1 and out_valid never asserts for the dropped request.
